snake_dir_ctrl: RTL and testbench

Upstream input stage for the snake game datapath. It turns the four raw active-low direction keys into the registered one-hot direction bus (dirInControl) that the snake logic samples on each game tick. It synchronises and debounces each key and rejects illegal turns (same direction or 180° reversal). A small FIFO holds fast key sequences so that two quick turns land on two consecutive game ticks.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_dir_ctrl_if.sv | 22 ++
 rtl/snake_dir_ctrl_key_debounce.sv | 46 ++++
 rtl/snake_dir_ctrl.sv | 96 +++++++++
 tb/tb_snake_dir_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, one-hot constants and helpers shared by the snake datapath
// Contents:
//   dir_e               2-bit direction code (right/left/down/up)
//   OH_*                one-hot direction constants, bit order matches the key bus
//   DEF_DEBOUNCE_CYCLES default debounce hold time (10 ms at 50 MHz)
//   opposite()          180-degree reversal of a direction code
//   dir_decode()        direction code to one-hot
package snake_pkg;
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    localparam logic [3:0] OH_RIGHT = 4'b0001;
    localparam logic [3:0] OH_LEFT  = 4'b0010;
    localparam logic [3:0] OH_DOWN  = 4'b0100;
    localparam logic [3:0] OH_UP    = 4'b1000;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    // Codes are paired so that flipping bit 0 gives the reverse direction
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    function automatic logic [3:0] dir_decode(input dir_e d);
        return 4'b0001 << d;
    endfunction
endpackage

// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: key/tick/freeze inputs and direction outputs of the direction controller
// Signals:
//   key_n    raw active-low keys [0]=right [1]=left [2]=down [3]=up
//   tick     one-cycle game-tick pulse
//   freeze   game over / paused
//   dir_out  one-hot current direction
//   pending  queued request count
//   drop     pulse when a legal request is lost to a full queue
// Modports: master drives keys/tick/freeze, slave (the controller) drives the outputs.
interface snake_dir_ctrl_if #(
    parameter int QUEUE_DEPTH = 2
);
    logic [3:0]                       key_n;
    logic                             tick;
    logic                             freeze;
    logic [3:0]                       dir_out;
    logic [$clog2(QUEUE_DEPTH+1)-1:0] pending;
    logic                             drop;

    modport master (output key_n, tick, freeze, input dir_out, pending, drop);
    modport slave  (input key_n, tick, freeze, output dir_out, pending, drop);
endinterface

// File: rtl/snake_dir_ctrl_key_debounce.sv
// key_debounce: single-key two-flop synchroniser, debounce counter and press-pulse generator
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   i_key_n  raw asynchronous active-low key
//   o_press  one-cycle pulse in the first cycle the debounced level reads pressed
import snake_pkg::*;

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= 2'b11;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_sync     <= {r_sync[0], i_key_n};
            r_stable_d <= r_stable;
            if (r_sync[1] == r_stable)
                r_cnt <= '0;
            else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Falling edge of the debounced level; releases produce nothing
    assign o_press = r_stable_d & ~r_stable;
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: debounced direction keys filtered for legal turns and queued onto game ticks
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      snake_dir_ctrl_if.slave: key_n/tick/freeze in, dir_out/pending/drop out
import snake_pkg::*;

module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int QUEUE_DEPTH     = 2
) (
    input logic             clk,
    input logic             reset_n,
    snake_dir_ctrl_if.slave bus
);
    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(QUEUE_DEPTH - 1);
    localparam logic [PW-1:0] CNT_FULL = PW'(QUEUE_DEPTH);

    logic [3:0]    w_press;
    dir_e          w_req;
    dir_e          w_ref;
    logic [AW-1:0] w_last;
    logic          w_legal;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    dir_e          r_q [QUEUE_DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [PW-1:0] r_count;
    dir_e          r_dir;
    logic [3:0]    r_dir_oh;
    logic          r_drop;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk     (clk),
            .reset_n (reset_n),
            .i_key_n (bus.key_n[i]),
            .o_press (w_press[i])
        );
    end

    // Same-cycle presses: up > down > left > right, losers vanish silently
    assign w_req = w_press[DIR_UP]   ? DIR_UP   :
                   w_press[DIR_DOWN] ? DIR_DOWN :
                   w_press[DIR_LEFT] ? DIR_LEFT : DIR_RIGHT;

    // Turns are judged against the last queued request so a burst chains correctly;
    // this is the pre-pop tail even when the same edge pops it
    assign w_last  = (r_tail == '0) ? PTR_LAST : r_tail - 1'b1;
    assign w_ref   = (r_count != '0) ? r_q[w_last] : r_dir;
    assign w_legal = !bus.freeze && (|w_press) && (w_req != w_ref) && (w_req != opposite(w_ref));
    assign w_full  = (r_count == CNT_FULL);
    assign w_push  = w_legal && !w_full;
    assign w_pop   = bus.tick && !bus.freeze && (r_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                r_q[i] <= DIR_RIGHT;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_dir    <= DIR_RIGHT;
            r_dir_oh <= OH_RIGHT;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_legal && w_full;
            if (bus.freeze) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_q[r_tail] <= w_req;
                    r_tail      <= (r_tail == PTR_LAST) ? '0 : r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_dir    <= r_q[r_head];
                    r_dir_oh <= dir_decode(r_q[r_head]);
                    r_head   <= (r_head == PTR_LAST) ? '0 : r_head + 1'b1;
                end
                if (w_push != w_pop)
                    r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
            end
        end
    end

    assign bus.dir_out = r_dir_oh;
    assign bus.pending = r_count;
    assign bus.drop    = r_drop;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed self-checking bench for snake_dir_ctrl (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2)
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int drop_cnt = 0;

    always #5 clk = ~clk;

    snake_dir_ctrl_if #(.QUEUE_DEPTH(2)) bus();

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.drop === 1'b1) drop_cnt++;
    endtask

    task automatic do_reset();
        bus.key_n  = 4'b1111;
        bus.tick   = 1'b0;
        bus.freeze = 1'b0;
        reset_n    = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        drop_cnt = 0;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    // Key low for 10 cycles; press pulse lands in cycle 6, its edge (optionally with tick) closes cycle 6
    task automatic press_key(input int k, input logic tk);
        bus.key_n[k] = 1'b0;
        repeat (6) step();
        bus.tick = tk;
        step();
        bus.tick = 1'b0;
        repeat (3) step();
        bus.key_n[k] = 1'b1;
        repeat (7) step();
    endtask

    task automatic test_reset();
        bus.key_n  = 4'b1111;
        bus.tick   = 1'b0;
        bus.freeze = 1'b0;
        reset_n    = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL reset_dir: got %b want 0001", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL reset_pending: got %0d want 0", bus.pending); end
        n_cmp++; if (bus.drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", bus.drop); end
    endtask

    task automatic test_idle_tick();
        drop_cnt = 0;
        repeat (3) begin
            do_tick();
            n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL idle_tick_dir: got %b want 0001", bus.dir_out); end
        end
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL idle_pending: got %0d want 0", bus.pending); end
        n_cmp++; if (drop_cnt !== 0) begin n_err++; $display("FAIL idle_drop: got %0d pulses want 0", drop_cnt); end
    endtask

    task automatic test_glitch();
        bus.key_n[3] = 1'b0;
        repeat (3) step();
        bus.key_n[3] = 1'b1;
        repeat (10) step();
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL glitch_pending: got %0d want 0", bus.pending); end
    endtask

    task automatic test_press_latency();
        bus.key_n[3] = 1'b0;
        repeat (6) step();
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL latency_early: got %0d want 0", bus.pending); end
        step();
        n_cmp++; if (bus.pending !== 2'd1) begin n_err++; $display("FAIL latency_press: got %0d want 1", bus.pending); end
        repeat (3) step();
        bus.key_n[3] = 1'b1;
        repeat (7) step();
        n_cmp++; if (bus.pending !== 2'd1) begin n_err++; $display("FAIL held_single_event: got %0d want 1", bus.pending); end
        n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL dir_before_tick: got %b want 0001", bus.dir_out); end
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b1000) begin n_err++; $display("FAIL tick_dir_up: got %b want 1000", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL tick_pending: got %0d want 0", bus.pending); end
    endtask

    task automatic test_filter();
        do_reset();
        press_key(1, 1'b0);
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL filter_reverse: got %0d want 0", bus.pending); end
        press_key(0, 1'b0);
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL filter_same: got %0d want 0", bus.pending); end
        press_key(2, 1'b0);
        n_cmp++; if (bus.pending !== 2'd1) begin n_err++; $display("FAIL filter_down: got %0d want 1", bus.pending); end
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b0100) begin n_err++; $display("FAIL filter_dir_down: got %b want 0100", bus.dir_out); end
        n_cmp++; if (drop_cnt !== 0) begin n_err++; $display("FAIL filter_drop: got %0d pulses want 0", drop_cnt); end
    endtask

    task automatic test_queue_full();
        do_reset();
        press_key(3, 1'b0);
        press_key(1, 1'b0);
        n_cmp++; if (bus.pending !== 2'd2) begin n_err++; $display("FAIL queue_two: got %0d want 2", bus.pending); end
        n_cmp++; if (drop_cnt !== 0) begin n_err++; $display("FAIL queue_nodrop: got %0d pulses want 0", drop_cnt); end
        press_key(2, 1'b0);
        n_cmp++; if (bus.pending !== 2'd2) begin n_err++; $display("FAIL queue_full_pending: got %0d want 2", bus.pending); end
        n_cmp++; if (drop_cnt !== 1) begin n_err++; $display("FAIL queue_drop_pulse: got %0d pulses want 1", drop_cnt); end
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b1000) begin n_err++; $display("FAIL queue_pop1: got %b want 1000", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd1) begin n_err++; $display("FAIL queue_pop1_pending: got %0d want 1", bus.pending); end
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b0010) begin n_err++; $display("FAIL queue_pop2: got %b want 0010", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL queue_pop2_pending: got %0d want 0", bus.pending); end
    endtask

    task automatic test_push_pop();
        do_reset();
        press_key(3, 1'b0);
        press_key(1, 1'b1);
        n_cmp++; if (bus.dir_out !== 4'b1000) begin n_err++; $display("FAIL pushpop_dir: got %b want 1000", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd1) begin n_err++; $display("FAIL pushpop_pending: got %0d want 1", bus.pending); end
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b0010) begin n_err++; $display("FAIL pushpop_next: got %b want 0010", bus.dir_out); end
        do_reset();
        press_key(3, 1'b0);
        press_key(2, 1'b1);
        n_cmp++; if (bus.dir_out !== 4'b1000) begin n_err++; $display("FAIL pushpop_rev_dir: got %b want 1000", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL pushpop_rev_pending: got %0d want 0", bus.pending); end
        n_cmp++; if (drop_cnt !== 0) begin n_err++; $display("FAIL pushpop_drop: got %0d pulses want 0", drop_cnt); end
    endtask

    task automatic test_freeze();
        do_reset();
        press_key(3, 1'b0);
        press_key(1, 1'b0);
        n_cmp++; if (bus.pending !== 2'd2) begin n_err++; $display("FAIL freeze_setup: got %0d want 2", bus.pending); end
        bus.freeze = 1'b1;
        step();
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL freeze_flush: got %0d want 0", bus.pending); end
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL freeze_tick: got %b want 0001", bus.dir_out); end
        bus.key_n[2] = 1'b0;
        repeat (10) step();
        bus.freeze = 1'b0;
        repeat (10) step();
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL freeze_no_refire: got %0d want 0", bus.pending); end
        bus.key_n[2] = 1'b1;
        repeat (7) step();
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL unfreeze_dir: got %b want 0001", bus.dir_out); end
        n_cmp++; if (drop_cnt !== 0) begin n_err++; $display("FAIL freeze_drop: got %0d pulses want 0", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press_key(3, 1'b0);
        do_tick();
        n_cmp++; if (bus.dir_out !== 4'b1000) begin n_err++; $display("FAIL rstmid_setup: got %b want 1000", bus.dir_out); end
        bus.key_n[2] = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL rstmid_async_dir: got %b want 0001", bus.dir_out); end
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL rstmid_async_pending: got %0d want 0", bus.pending); end
        bus.key_n[2] = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (12) step();
        n_cmp++; if (bus.pending !== 2'd0) begin n_err++; $display("FAIL rstmid_stale: got %0d want 0", bus.pending); end
        n_cmp++; if (bus.dir_out !== 4'b0001) begin n_err++; $display("FAIL rstmid_dir: got %b want 0001", bus.dir_out); end
    endtask

    initial begin
        bus.key_n  = 4'b1111;
        bus.tick   = 1'b0;
        bus.freeze = 1'b0;
        test_reset();
        test_idle_tick();
        test_glitch();
        test_press_latency();
        test_filter();
        test_queue_full();
        test_push_pop();
        test_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
